// File: rtl/sim_mem_bridge.sv
// Simulation memory slave for the Picorv32 native bus: word SRAM, fixed wait states, console and pass MMIO.
// Optional RANDOM_STALL_EN adds 0..7 LFSR-driven extra wait cycles per access.
module sim_mem_bridge #(
  parameter int unsigned DEPTH        = 65536,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] PASS_VALUE   = 32'd123456789,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clock,
  input  logic        resetn,
  // Handshake: the core raises mem_valid and holds addr/wdata/wstrb stable until
  // it sees mem_ready, which is a one-cycle pulse; dropping mem_valid early aborts.
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        tests_passed,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        bus_error,
  output logic [1:0]  dbg_state_o   // 0=IDLE, 1=WAIT, 2=RESP
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_e;

  if (LFSR_SEED == 16'h0 || DEPTH != (2 ** ADDR_W) || WAIT_CYCLES > 247) begin : g_bad_params
    $error("sim_mem_bridge: illegal parameter combination");
  end

  logic [31:0] sram [0:DEPTH-1];

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        ready_q, passed_q, cvalid_q, berr_q;
  logic [31:0] rdata_q;
  logic [7:0]  cdata_q;

  logic [ADDR_W-1:0] idx;
  logic              in_range, is_console, is_pass, is_write, fire;
  logic [7:0]        wait_load;
  logic              unused_addr_lsbs;

  assign idx              = mem_addr[ADDR_W+1:2];
  assign in_range         = (mem_addr[31:ADDR_W+2] == '0);
  assign is_console       = (mem_addr[31:2] == CONSOLE_ADDR[31:2]);
  assign is_pass          = (mem_addr[31:2] == PASS_ADDR[31:2]);
  assign is_write         = |mem_wstrb;
  assign unused_addr_lsbs = ^mem_addr[1:0];

`ifdef RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign wait_load = 8'(WAIT_CYCLES) + {5'd0, lfsr_q[2:0]};

  always_ff @(posedge clock) begin
    if (!resetn) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end
`else
  assign wait_load = 8'(WAIT_CYCLES);
`endif

  // The access is performed on the edge that enters RESP so its results are visible in RESP.
  assign fire = mem_valid &&
                (((state_q == ST_IDLE) && (wait_load == 8'd0)) ||
                 ((state_q == ST_WAIT) && (cnt_q == 8'd1)));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      ready_q  <= 1'b0;
      rdata_q  <= 32'h0;
      passed_q <= 1'b0;
      cvalid_q <= 1'b0;
      cdata_q  <= 8'h0;
      berr_q   <= 1'b0;
    end else begin
      ready_q  <= 1'b0;
      cvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_valid) begin
            cnt_q   <= wait_load;
            state_q <= (wait_load == 8'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!mem_valid) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_q <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      if (fire) begin
        ready_q <= 1'b1;
        if (!is_write) begin
          if (in_range)                    rdata_q <= sram[idx];
          else if (is_console || is_pass)  rdata_q <= 32'h0;
          else                             rdata_q <= 32'hDEAD_BEEF;
        end
        if (is_write && is_console) begin
          cvalid_q <= 1'b1;
          cdata_q  <= mem_wdata[7:0];
        end
        if (is_write && is_pass && (mem_wdata == PASS_VALUE)) passed_q <= 1'b1;
        if (!in_range && !is_console && !is_pass) berr_q <= 1'b1;
      end
    end
  end

  // SRAM contents survive reset; only the commit is gated by it.
  always_ff @(posedge clock) begin
    if (resetn && fire && is_write && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) sram[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign mem_ready     = ready_q;
  assign mem_rdata     = rdata_q;
  assign tests_passed  = passed_q;
  assign console_valid = cvalid_q;
  assign console_data  = cdata_q;
  assign bus_error     = berr_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/sim_mem_bridge.md
Name: sim_mem_bridge

Overview:
- Simulation-side memory slave for the Chisel Picorv32 native memory interface (valid/ready, addr, wdata, wstrb, rdata).
- Sits directly downstream of the core in the system testbench. Provides a preloadable word SRAM plus the configurable wait-state latency the core's memory FSM must tolerate.
- Decodes two MMIO locations:
  - console character output;
  - test-pass signature register, which drives tests_passed to the trap/finish logic.

Parameters:
- DEPTH, 65536, number of 32-bit SRAM words; array is named sram, indexed [0:DEPTH-1], for hierarchical preload.
- ADDR_W, 16, word-index width; DEPTH == 2**ADDR_W.
- WAIT_CYCLES, 0, fixed extra cycles between accept and mem_ready; legal range 0..247.
- CONSOLE_ADDR, 32'h1000_0000, byte address of the console write port.
- PASS_ADDR, 32'h2000_0000, byte address of the pass-signature register.
- PASS_VALUE, 32'd123456789, signature value that sets tests_passed.
- LFSR_SEED, 16'hACE1, reset seed for the stall LFSR (optional feature only); must be nonzero.

Ports:
- clock  in  1  clock
- resetn  in  1  synchronous, active-low reset
- mem_valid  in  1  request from core; held stable with addr/wdata/wstrb until mem_ready
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables; 0 = read
- mem_rdata  out  32  read data, valid in the mem_ready cycle
- tests_passed  out  1  sticky pass flag
- console_valid  out  1  one-cycle pulse on a console write
- console_data  out  8  console character
- bus_error  out  1  sticky out-of-range access flag

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, tests_passed=0, console_valid=0, console_data=0, bus_error=0, FSM=IDLE, wait counter=0. sram contents are NOT reset.
- FSM states: IDLE, WAIT, RESP. 8-bit wait counter.
  - IDLE: if mem_valid, accept the request in cycle T. Load counter with the wait count. Go to WAIT if the count is greater than 0, else go to RESP.
  - WAIT: decrement the counter. Go to RESP when the counter reaches 1.
  - If mem_valid drops in WAIT (protocol violation): abort to IDLE; no write, no ready, no MMIO side effect.
  - RESP: perform the access and drive mem_ready=1 for exactly one cycle, then return to IDLE.
- Latency: mem_ready is high in cycle T+1+wait. The earliest next accept is the cycle after RESP.
- Index = mem_addr[ADDR_W+1:2]. An address is "in range" when mem_addr[31:ADDR_W+2]==0.
- Read, in range: mem_rdata <= sram[index], registered so it is valid in the RESP cycle. mem_rdata holds until the next RESP.
- Write, in range: sram[index] bytes b, for each b with mem_wstrb[b]=1, take mem_wdata[8b+7:8b]; other bytes are unchanged. Committed at RESP.
- Write to CONSOLE_ADDR (word match): console_valid=1 and console_data=mem_wdata[7:0] in the RESP cycle.
- Write to PASS_ADDR with mem_wdata==PASS_VALUE: tests_passed <= 1, sticky until reset. Any other value is ignored.
- Reads of MMIO addresses return 32'h0.
- Out-of-range, non-MMIO access:
  - read returns 32'hDEAD_BEEF;
  - write is dropped;
  - bus_error <= 1 (sticky);
  - the handshake still completes normally.
- Read-after-write to the same word in back-to-back transactions returns the new data.
- Reset mid-operation: the FSM returns to IDLE and all outputs take reset values in the next cycle. A pending write is discarded.

Optional Feature:
- Macro: RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded with LFSR_SEED on reset and advances every cycle.
  - At accept, wait = WAIT_CYCLES + lfsr[2:0], giving 0..7 extra cycles.
  - The stall sequence is deterministic for a given seed.
- Undefined: no LFSR logic; wait = WAIT_CYCLES exactly.

Test Plan:
- WAIT_CYCLES=0: read of preloaded sram[4]=32'h1234_5678 (addr 32'h10) accepted at T -> mem_ready=1 only at T+1, mem_rdata=32'h1234_5678.
- WAIT_CYCLES=3: write 32'hAABBCCDD, wstrb=4'b0101, to addr 32'h20 over old 32'h0 -> ready at T+4; subsequent read of 32'h20 returns 32'h00BB00DD.
- Write 32'h41 to 32'h1000_0000 -> console_valid single pulse, console_data=8'h41, sram unchanged. Write 5 to PASS_ADDR -> tests_passed stays 0. Write 123456789 -> tests_passed=1 and stays 1.
- Read 32'h0004_0000 (out of range, DEPTH=65536) -> ready after normal latency, mem_rdata=32'hDEAD_BEEF, bus_error=1 and sticky.
- WAIT_CYCLES=5, mem_valid dropped at T+2 -> no mem_ready, target word unchanged, FSM accepts a new request next cycle. resetn=0 during WAIT -> all outputs 0 next cycle.
- RANDOM_STALL_EN defined, 1000 random reads/writes -> every latency within 1..8 cycles and the data scoreboard matches a reference model.
